data_mem_responder: RTL

Memory-side responder for the processor's data-memory interface. It accepts single-cycle read and write strobes from the control unit's MEM phase, holds a small register-file memory, and signals completion after a configurable number of wait states. Read data is returned through a registered, one-cycle-valid response, and write completion is returned as an acknowledge pulse. The block sits between the control unit and the register file / writeback path.

---
 rtl/data_mem_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts single-cycle read/write strobes, waits LATENCY
// cycles, then returns a registered read response or a write acknowledge.
module data_mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              busy,
    output logic              err_conflict,
    output logic              err_overrun
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [3:0]          wait_cnt, wait_cnt_next;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic                cap_write;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                conflict;
    logic                dropped;
    logic                enter_resp;
    logic                op_write;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        conflict      = 1'b0;
        case (state)
            S_IDLE: begin
                conflict = mem_read && mem_write;
                accept   = mem_read ^ mem_write;
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // With zero latency the response edge is the accept edge, so the live request is used.
    always_comb begin
        enter_resp = (state_next == S_RESP);
        dropped    = (state != S_IDLE) && (mem_read || mem_write);
        op_write   = (state == S_IDLE) ? mem_write : cap_write;
        op_addr    = (state == S_IDLE) ? addr      : cap_addr;
        op_wdata   = (state == S_IDLE) ? wdata     : cap_wdata;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_write    <= 1'b0;
            rdata        <= '0;
            rd_valid     <= 1'b0;
            wr_ack       <= 1'b0;
            err_conflict <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            state        <= state_next;
            wait_cnt     <= wait_cnt_next;
            rd_valid     <= enter_resp && !op_write;
            wr_ack       <= enter_resp && op_write;
            err_conflict <= conflict;
            err_overrun  <= err_overrun || dropped;
            if (accept) begin
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_write <= mem_write;
            end
            if (enter_resp && !op_write) begin
                rdata <= mem[op_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enter_resp && op_write) begin
            mem[op_addr] <= op_wdata;
        end
    end

endmodule
